// File: rtl/tc_gate_pkg.sv
// Shared types and truth-table constants for gate-level self-checking blocks.
package tc_gate_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int SETTLE_W = 8;

    localparam logic [3:0] TT_SECOND_TICK = 4'b0010;
    localparam logic [3:0] TT_AND         = 4'b1000;
    localparam logic [3:0] TT_OR          = 4'b1110;
    localparam logic [3:0] TT_XOR         = 4'b0110;

endpackage

// File: rtl/settle_timer.sv
// Loadable 8-bit down-counter with zero flag; load wins over decrement.
// Decrements only while dec is high and the count is non-zero, then holds at 0.
module settle_timer
    import tc_gate_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    input  logic                dec,
    output logic                zero
);

    logic [SETTLE_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/truth_table_checker.sv
// Walks all 2**N_IN input vectors, holds each SETTLE cycles, then checks dut_out against TRUTH.
// One run takes 2**N_IN*(SETTLE+1) busy cycles plus a DONE cycle; start is honoured only in IDLE.
module truth_table_checker
    import tc_gate_pkg::*;
#(
    parameter int                 N_IN   = 2,
    parameter logic [2**N_IN-1:0] TRUTH  = TT_SECOND_TICK,
    parameter int                 SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            dut_out,
    output logic [N_IN-1:0] stim,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] first_fail_idx
);

    if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
        $error("truth_table_checker: SETTLE must be in 1..255");
    end
    if (N_IN < 1 || N_IN > 6) begin : g_bad_n_in
        $error("truth_table_checker: N_IN must be in 1..6");
    end

    localparam int                 NV     = 2**N_IN;
    localparam logic [N_IN-1:0]    LAST   = N_IN'(NV - 1);
    localparam logic [N_IN:0]      ERR_MX = (N_IN+1)'(NV);
    localparam logic [SETTLE_W-1:0] RELOAD = SETTLE_W'(SETTLE - 1);

    state_t          state;
    logic [N_IN-1:0] idx;
    logic            mismatch;
    logic [N_IN:0]   err_next;
    logic            timer_load;
    logic            timer_zero;

    assign mismatch   = (dut_out != TRUTH[idx]);
    assign err_next   = (mismatch && err_count != ERR_MX) ? err_count + 1'b1 : err_count;
    assign timer_load = (state == IDLE && start) || (state == CHECK && idx != LAST);
    assign busy       = (state == WAIT) || (state == CHECK);
    assign stim       = idx;

    settle_timer u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (RELOAD),
        .dec      (state == WAIT),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_idx <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= WAIT;
                        idx        <= '0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        pass       <= 1'b0;
                    end
                end
                WAIT: begin
                    if (timer_zero) state <= CHECK;
                end
                CHECK: begin
                    err_count <= err_next;
                    if (mismatch && !fail_valid) begin
                        first_fail_idx <= idx;
                        fail_valid     <= 1'b1;
                    end
                    // pass is set on entry to DONE so it is already valid alongside the done pulse
                    if (idx == LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= WAIT;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed-vector bench: default 2-input instance with selectable gate model, plus a 3-input XOR instance.
module tb_truth_table_checker;
    import tc_gate_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // default instance: N_IN=2, SETTLE=1, TRUTH = a & ~b
    logic       start0 = 1'b0;
    logic       dut_out0;
    logic [1:0] stim0;
    logic       busy0, done0, pass0, fv0;
    logic [2:0] err0;
    logic [1:0] ffi0;
    int         mode = 0;   // 0: a&~b, 1: a&b, 2: stuck at 1

    assign dut_out0 = (mode == 0) ? (stim0[0] & ~stim0[1]) :
                      (mode == 1) ? (stim0[0] & stim0[1]) : 1'b1;

    truth_table_checker u0 (
        .clk(clk), .rst(rst), .start(start0), .dut_out(dut_out0), .stim(stim0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .fail_valid(fv0), .first_fail_idx(ffi0)
    );

    // 3-input XOR instance with long settle
    logic       start1 = 1'b0;
    logic       dut_out1;
    logic [2:0] stim1;
    logic       busy1, done1, pass1, fv1;
    logic [3:0] err1;
    logic [2:0] ffi1;

    assign dut_out1 = ^stim1;

    truth_table_checker #(.N_IN(3), .TRUTH(8'h96), .SETTLE(3)) u1 (
        .clk(clk), .rst(rst), .start(start1), .dut_out(dut_out1), .stim(stim1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_valid(fv1), .first_fail_idx(ffi1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Logs indexed by cycle number: cycle k is the interval after edge k, edge 0 samples start.
    int         done_cyc;
    int         n_done;
    logic [1:0] stim_log [0:63];
    logic       busy_log [0:63];
    logic       pass_log [0:63];
    logic [2:0] err_log  [0:63];
    logic       fv_log   [0:63];
    logic       rp, rfv;
    logic [2:0] re;
    logic [1:0] rffi;

    task automatic run0(input bit hold, input int ncyc);
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        if (!hold) start0 = 1'b0;
        done_cyc = 0;
        n_done   = 0;
        for (int c = 1; c <= ncyc; c++) begin
            if (c > 1) @(negedge clk);
            if (hold && c == 10) start0 = 1'b0;
            stim_log[c] = stim0;
            busy_log[c] = busy0;
            pass_log[c] = pass0;
            err_log[c]  = err0;
            fv_log[c]   = fv0;
            if (done0) begin
                n_done++;
                if (done_cyc == 0) begin
                    done_cyc = c;
                    rp = pass0; re = err0; rfv = fv0; rffi = ffi0;
                end
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        expect_eq("rst_stim", 32'(stim0), 0);
        expect_eq("rst_busy", 32'(busy0), 0);
        expect_eq("rst_done", 32'(done0), 0);
        expect_eq("rst_pass", 32'(pass0), 0);
        expect_eq("rst_err", 32'(err0), 0);
        expect_eq("rst_fv", 32'(fv0), 0);
        expect_eq("rst_ffi", 32'(ffi0), 0);
        rst = 1'b0;
        @(negedge clk);

        // a&~b matches TRUTH: vectors 0,1,2,3 each held two cycles
        mode = 0;
        run0(1'b0, 12);
        for (int c = 1; c <= 8; c++) begin
            expect_eq($sformatf("t1_stim_c%0d", c), 32'(stim_log[c]), 32'((c - 1) / 2));
            expect_eq($sformatf("t1_busy_c%0d", c), 32'(busy_log[c]), 1);
        end
        expect_eq("t1_busy_c9", 32'(busy_log[9]), 0);
        expect_eq("t1_done_cyc", done_cyc, 9);
        expect_eq("t1_n_done", n_done, 1);
        expect_eq("t1_pass", 32'(rp), 1);
        expect_eq("t1_err", 32'(re), 0);
        expect_eq("t1_fv", 32'(rfv), 0);
        expect_eq("t1_stim_hold", 32'(stim_log[12]), 3);

        // a&b: mismatches at 1 and 3; start also clears previous pass
        mode = 1;
        run0(1'b0, 12);
        expect_eq("t2_pass_clr_c1", 32'(pass_log[1]), 0);
        expect_eq("t2_done_cyc", done_cyc, 9);
        expect_eq("t2_pass", 32'(rp), 0);
        expect_eq("t2_err", 32'(re), 2);
        expect_eq("t2_fv", 32'(rfv), 1);
        expect_eq("t2_ffi", 32'(rffi), 1);
        expect_eq("t2_err_c4", 32'(err_log[4]), 0);
        expect_eq("t2_err_c5", 32'(err_log[5]), 1);

        // stuck-at-1: mismatches at 0,2,3; start clears previous err/fail_valid
        mode = 2;
        run0(1'b0, 12);
        expect_eq("t3_err_clr_c1", 32'(err_log[1]), 0);
        expect_eq("t3_fv_clr_c1", 32'(fv_log[1]), 0);
        expect_eq("t3_done_cyc", done_cyc, 9);
        expect_eq("t3_err", 32'(re), 3);
        expect_eq("t3_ffi", 32'(rffi), 0);
        expect_eq("t3_pass", 32'(rp), 0);

        // reset mid-run: asserted in cycle 4, reset values in cycle 5, no done afterwards
        mode = 0;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expect_eq("t4_stim", 32'(stim0), 0);
        expect_eq("t4_busy", 32'(busy0), 0);
        expect_eq("t4_err", 32'(err0), 0);
        expect_eq("t4_fv", 32'(fv0), 0);
        expect_eq("t4_pass", 32'(pass0), 0);
        n_done = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done0) n_done++;
        end
        expect_eq("t4_no_done", n_done, 0);
        run0(1'b0, 12);
        expect_eq("t4_rerun_done_cyc", done_cyc, 9);
        expect_eq("t4_rerun_pass", 32'(rp), 1);

        // start held through DONE: exactly one run, then a new pulse in IDLE clears pass
        run0(1'b1, 16);
        expect_eq("t5_done_cyc", done_cyc, 9);
        expect_eq("t5_n_done", n_done, 1);
        expect_eq("t5_busy_c11", 32'(busy_log[11]), 0);
        expect_eq("t5_pass_c12", 32'(pass_log[12]), 1);
        expect_eq("t5_stim_c12", 32'(stim_log[12]), 3);
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        expect_eq("t5_pass_clr", 32'(pass0), 0);
        expect_eq("t5_err_clr", 32'(err0), 0);
        expect_eq("t5_busy_new", 32'(busy0), 1);
        repeat (12) @(negedge clk);

        // 3-input XOR, SETTLE=3: done at cycle 8*4+1 = 33
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        done_cyc = 0;
        n_done   = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 4) expect_eq("t6_stim_c4", 32'(stim1), 0);
            if (c == 5) expect_eq("t6_stim_c5", 32'(stim1), 1);
            if (c == 32) expect_eq("t6_busy_c32", 32'(busy1), 1);
            if (done1) begin
                n_done++;
                if (done_cyc == 0) begin
                    done_cyc = c;
                    expect_eq("t6_pass", 32'(pass1), 1);
                    expect_eq("t6_err", 32'(err1), 0);
                    expect_eq("t6_fv", 32'(fv1), 0);
                end
            end
        end
        expect_eq("t6_done_cyc", done_cyc, 33);
        expect_eq("t6_n_done", n_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
